// File: rtl/top_apb_demux.sv
// APB 1-to-8 address demultiplexer.
//
// Routes one APB master onto eight APB slaves. paddr_i[30:28] selects the slave.
// Addresses with paddr_i[31] set map to no slave, and the block answers them
// locally with an error.
//
// Parameters:
//   TIMEOUT_CYCLES  ACCESS cycles with pready low before a forced error
//                   (APB_DEMUX_TIMEOUT_EN builds only)
//
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   psel_i/paddr_i/pwrite_i/penable_i/    master request
//   pwdata_i
//   prdata_o/pready_o/pslverr_o           master response
//   psel_o/paddr_o/pwrite_o/penable_o/    per-slave request, unselected slaves held at 0
//   pwdata_o [8]
//   prdata_i/pready_i/pslverr_i [8]       per-slave response
//
// Configuration macro:
//   APB_DEMUX_TIMEOUT_EN  when defined, a slave that stalls for TIMEOUT_CYCLES ACCESS
//                         cycles is cut off, and the master gets an error response.
module top_apb_demux #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        psel_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic        penable_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        psel_o    [8],
  output logic [31:0] paddr_o   [8],
  output logic        pwrite_o  [8],
  output logic        penable_o [8],
  output logic [31:0] pwdata_o  [8],
  input  logic [31:0] prdata_i  [8],
  input  logic        pready_i  [8],
  input  logic        pslverr_i [8]
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d, dec_idx, idx;
  logic       mapped_q, mapped_d, dec_mapped, mapped;
  logic       blk_q, blk_d;
  logic       route_q, en, access, timeout;

  assign dec_idx    = paddr_i[30:28];
  assign dec_mapped = ~paddr_i[31];

  // An ACCESS cycle that follows SETUP or a wait state uses the captured route.
  // An ACCESS cycle straight from idle decodes on the fly.
  assign route_q = penable_i && (state_q != StIdle);
  assign idx     = route_q ? idx_q : dec_idx;
  assign mapped  = route_q ? mapped_q : dec_mapped;

  // blk_q suppresses a transfer that was in flight across a reset.
  // It stays set until the master leaves ACCESS.
  assign en     = rst_ni && psel_i && !(blk_q && penable_i);
  assign access = en && penable_i;

`ifdef APB_DEMUX_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = access && mapped && (cnt_q == CntW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = '0;
    if (access && mapped && !pready_i[idx] && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // No timeout logic in this build. The parameter is still referenced to keep its use visible.
  assign timeout = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      psel_o[k]    = 1'b0;
      penable_o[k] = 1'b0;
      paddr_o[k]   = '0;
      pwrite_o[k]  = 1'b0;
      pwdata_o[k]  = '0;
    end
    prdata_o  = '0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;

    if (en && mapped) begin
      psel_o[idx]    = psel_i;
      penable_o[idx] = penable_i && !timeout;
      paddr_o[idx]   = paddr_i;
      pwrite_o[idx]  = pwrite_i;
      pwdata_o[idx]  = pwdata_i;
    end

    if (access) begin
      if (!mapped || timeout) begin
        pready_o  = 1'b1;
        pslverr_o = 1'b1;
      end else begin
        prdata_o  = prdata_i[idx];
        pready_o  = pready_i[idx];
        pslverr_o = pslverr_i[idx];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mapped_d = mapped_q;
    blk_d    = blk_q && psel_i && penable_i;

    if (!en) begin
      state_d = StIdle;
    end else if (!penable_i) begin
      state_d = StSetup;
    end else if (pready_o) begin
      state_d = StIdle;
    end else begin
      state_d = StAccess;
    end

    if (en && (!penable_i || state_q == StIdle)) begin
      idx_d    = dec_idx;
      mapped_d = dec_mapped;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      mapped_q <= 1'b0;
      blk_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mapped_q <= mapped_d;
      blk_q    <= blk_d;
    end
  end

endmodule

// File: tb/tb_top_apb_demux.sv
module tb_top_apb_demux;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        psel_i, pwrite_i, penable_i;
  logic [31:0] paddr_i, pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic        psel_o    [8];
  logic [31:0] paddr_o   [8];
  logic        pwrite_o  [8];
  logic        penable_o [8];
  logic [31:0] pwdata_o  [8];
  logic [31:0] prdata_i  [8];
  logic        pready_i  [8];
  logic        pslverr_i [8];

  int n_checks = 0;
  int n_fail   = 0;

  top_apb_demux #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .psel_i    (psel_i),
    .paddr_i   (paddr_i),
    .pwrite_i  (pwrite_i),
    .penable_i (penable_i),
    .pwdata_i  (pwdata_i),
    .prdata_o  (prdata_o),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o),
    .psel_o    (psel_o),
    .paddr_o   (paddr_o),
    .pwrite_o  (pwrite_o),
    .penable_o (penable_o),
    .pwdata_o  (pwdata_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] sel_vec, en_vec;
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sel_vec[i] = psel_o[i];
      en_vec[i]  = penable_o[i];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  sel;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    @(negedge clk_i);
    psel_i    = 1'b0;
    penable_i = 1'b0;
    paddr_i   = '0;
    pwrite_i  = 1'b0;
    pwdata_i  = '0;
  endtask

  // Runs one complete transfer (SETUP and ACCESS) against a slave that is always ready.
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] unsel_or;
    @(negedge clk_i);
    psel_i    = 1'b1;
    penable_i = 1'b0;
    paddr_i   = v.addr;
    pwrite_i  = v.wr;
    pwdata_i  = v.wdata;
    #4;
    check({tag, " setup psel"}, 32'(sel_vec), 32'(v.sel));
    check({tag, " setup penable"}, 32'(en_vec), 32'h0);
    check({tag, " setup pready"}, 32'(pready_o), 32'h0);
    @(negedge clk_i);
    penable_i = 1'b1;
    #4;
    check({tag, " access psel"}, 32'(sel_vec), 32'(v.sel));
    check({tag, " access penable"}, 32'(en_vec), 32'(v.sel));
    check({tag, " pready"}, 32'(pready_o), 32'h1);
    check({tag, " pslverr"}, 32'(pslverr_o), 32'(v.err));
    check({tag, " prdata"}, prdata_o, v.rdata);
    unsel_or = '0;
    for (int i = 0; i < 8; i++) begin
      if (v.sel[i]) begin
        check({tag, " paddr_o"}, paddr_o[i], v.addr);
        check({tag, " pwrite_o"}, 32'(pwrite_o[i]), 32'(v.wr));
        check({tag, " pwdata_o"}, pwdata_o[i], v.wdata);
      end else begin
        unsel_or = unsel_or | pwdata_o[i] | paddr_o[i];
      end
    end
    check({tag, " unselected bus zero"}, unsel_or, 32'h0);
    idle_bus();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h0000_1000, 1'b1, 32'h1234_5678, 8'h01, 32'hCAFE_BEE0, 1'b0};
    vecs[1] = '{32'h1000_2000, 1'b0, 32'h0000_0000, 8'h02, 32'hCAFE_BEE1, 1'b0};
    vecs[2] = '{32'h4000_0001, 1'b0, 32'h0000_0000, 8'h10, 32'hCAFE_BEE4, 1'b0};
    vecs[3] = '{32'h7000_0020, 1'b0, 32'h0000_0000, 8'h80, 32'hCAFE_BEE7, 1'b0};
    vecs[4] = '{32'h8000_0000, 1'b0, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'hF000_0000, 1'b1, 32'h0000_DEAD, 8'h00, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h3FFF_FFFC, 1'b1, 32'hAAAA_5555, 8'h08, 32'hCAFE_BEE3, 1'b0};

    for (int i = 0; i < 8; i++) begin
      prdata_i[i]  = 32'hCAFE_BEE0 + 32'(i);
      pready_i[i]  = 1'b1;
      pslverr_i[i] = 1'b0;
    end
    rst_ni    = 1'b0;
    psel_i    = 1'b0;
    penable_i = 1'b0;
    paddr_i   = '0;
    pwrite_i  = 1'b0;
    pwdata_i  = '0;

    // Outputs while reset is held.
    #12;
    check("reset psel", 32'(sel_vec), 32'h0);
    check("reset penable", 32'(en_vec), 32'h0);
    check("reset pready", 32'(pready_o), 32'h0);
    check("reset pslverr", 32'(pslverr_o), 32'h0);
    check("reset prdata", prdata_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Wait states from slave 6; an address change mid-ACCESS must not reroute the transfer.
    pready_i[6] = 1'b0;
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h6000_00F0; pwrite_i = 1'b1;
    pwdata_i = 32'h0BAD_F00D;
    @(negedge clk_i);
    penable_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) paddr_i = 32'h1000_0000;
      #4;
      check($sformatf("wait%0d pready", c), 32'(pready_o), 32'h0);
      check($sformatf("wait%0d psel", c), 32'(sel_vec), 32'h40);
      @(negedge clk_i);
    end
    pready_i[6] = 1'b1; pslverr_i[6] = 1'b1;
    #4;
    check("wait done pready", 32'(pready_o), 32'h1);
    check("wait done pslverr", 32'(pslverr_o), 32'h1);
    check("wait done pwdata", pwdata_o[6], 32'h0BAD_F00D);
    idle_bus();
    pslverr_i[6] = 1'b0;

    // Reset pulsed during ACCESS to slave 2.
    pready_i[2] = 1'b0;
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h2000_0000; pwrite_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    #4;
    check("pre-reset psel", 32'(sel_vec), 32'h04);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mid-reset psel", 32'(sel_vec), 32'h0);
    check("mid-reset penable", 32'(en_vec), 32'h0);
    check("mid-reset pready", 32'(pready_o), 32'h0);
    #2;
    rst_ni = 1'b1;
    pready_i[2] = 1'b1;
    @(negedge clk_i);
    #4;
    check("post-reset no pready", 32'(pready_o), 32'h0);
    check("post-reset no psel", 32'(sel_vec), 32'h0);
    idle_bus();
    run_vec('{32'h3000_0000, 1'b0, 32'h0, 8'h08, 32'hCAFE_BEE3, 1'b0}, "after reset");

    // ACCESS straight from idle without a SETUP cycle.
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b1; paddr_i = 32'h5000_0000; pwrite_i = 1'b0;
    #4;
    check("direct psel", 32'(sel_vec), 32'h20);
    check("direct penable", 32'(en_vec), 32'h20);
    check("direct pready", 32'(pready_o), 32'h1);
    check("direct prdata", prdata_o, 32'hCAFE_BEE5);
    idle_bus();

    // Abandoned transfer: psel drops while slave 1 is stalled.
    pready_i[1] = 1'b0;
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h1000_0000;
    @(negedge clk_i);
    penable_i = 1'b1;
    idle_bus();
    #4;
    check("abandon psel", 32'(sel_vec), 32'h0);
    check("abandon pready", 32'(pready_o), 32'h0);
    pready_i[1] = 1'b1;
    run_vec(vecs[1], "after abandon");

`ifdef APB_DEMUX_TIMEOUT_EN
    pready_i[5] = 1'b0;
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h5000_0000;
    @(negedge clk_i);
    penable_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #4;
      check($sformatf("timeout wait%0d pready", c), 32'(pready_o), 32'h0);
      @(negedge clk_i);
    end
    #4;
    check("timeout pready", 32'(pready_o), 32'h1);
    check("timeout pslverr", 32'(pslverr_o), 32'h1);
    check("timeout prdata", prdata_o, 32'h0);
    check("timeout penable", 32'(en_vec), 32'h0);
    idle_bus();
    pready_i[5] = 1'b1;
`endif

    idle_bus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
